// File: rtl/axi_sram_bridge_mp.sv
// Bridge from N_PORTS SRAM-like core ports to one AXI3 master with independent read and write engines.
// Fixed priority (highest index wins) and read-after-write hazard blocking against the in-flight write.
module axi_sram_bridge_mp #(
    parameter int N_PORTS = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,
    input  logic [N_PORTS-1:0]        req_i,
    input  logic [N_PORTS-1:0]        wr_i,
    input  logic [2*N_PORTS-1:0]      size_i,
    input  logic [ADDR_W*N_PORTS-1:0] addr_i,
    input  logic [32*N_PORTS-1:0]     wdata_i,
    output logic [N_PORTS-1:0]        addr_ok_o,
    output logic [N_PORTS-1:0]        data_ok_o,
    output logic [31:0]               rdata_o,
    output logic [N_PORTS-1:0]        bus_err_o,
    output logic [ID_W-1:0]           arid_o,
    output logic [ADDR_W-1:0]         araddr_o,
    output logic [3:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic [1:0]                arlock_o,
    output logic [3:0]                arcache_o,
    output logic [2:0]                arprot_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [ID_W-1:0]           rid_i,
    input  logic [31:0]               rdata_axi_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic [ID_W-1:0]           awid_o,
    output logic [ADDR_W-1:0]         awaddr_o,
    output logic [3:0]                awlen_o,
    output logic [2:0]                awsize_o,
    output logic [1:0]                awburst_o,
    output logic [1:0]                awlock_o,
    output logic [3:0]                awcache_o,
    output logic [2:0]                awprot_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ID_W-1:0]           wid_o,
    output logic [31:0]               wdata_axi_o,
    output logic [3:0]                wstrb_o,
    output logic                      wlast_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    input  logic [ID_W-1:0]           bid_i,
    input  logic [1:0]                bresp_i,
    input  logic                      bvalid_i,
    output logic                      bready_o
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_e;

    r_state_e            r_state_q;
    w_state_e            w_state_q;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
    logic [1:0]          r_size_q, w_size_q;
    logic [PW-1:0]       r_port_q, w_port_q;
    logic [31:0]         w_data_q, rdata_q;
    logic [3:0]          w_strb_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [N_PORTS-1:0]  r_dok_q, r_err_q, w_dok_q, w_err_q;

    logic [N_PORTS-1:0]  hazard;
    logic                rd_any, wr_any, rd_gnt, wr_gnt;
    logic [PW-1:0]       rd_sel, wr_sel;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;
    logic [1:0]          rd_size, wr_size;
    logic [31:0]         wr_data;

    // IDs are not needed: at most one read and one write are ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{rid_i, bid_i};

    function automatic logic [3:0] strb_f(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    always_comb begin
        hazard = '0;
        for (int i = 0; i < N_PORTS; i++)
            hazard[i] = (w_state_q != W_IDLE) &&
                        (addr_i[i*ADDR_W+2 +: ADDR_W-2] == w_addr_q[ADDR_W-1:2]);
    end

    always_comb begin
        rd_any  = 1'b0;
        rd_sel  = '0;
        rd_addr = '0;
        rd_size = '0;
        wr_any  = 1'b0;
        wr_sel  = '0;
        wr_addr = '0;
        wr_size = '0;
        wr_data = '0;
        // Later (higher) indices overwrite earlier ones, giving fixed priority.
        for (int i = 0; i < N_PORTS; i++) begin
            if (req_i[i] && !wr_i[i] && !hazard[i]) begin
                rd_any  = 1'b1;
                rd_sel  = PW'(i);
                rd_addr = addr_i[i*ADDR_W +: ADDR_W];
                rd_size = size_i[2*i +: 2];
            end
            if (req_i[i] && wr_i[i]) begin
                wr_any  = 1'b1;
                wr_sel  = PW'(i);
                wr_addr = addr_i[i*ADDR_W +: ADDR_W];
                wr_size = size_i[2*i +: 2];
                wr_data = wdata_i[32*i +: 32];
            end
        end
        rd_gnt    = aresetn_i && (r_state_q == R_IDLE) && rd_any;
        wr_gnt    = aresetn_i && (w_state_q == W_IDLE) && wr_any;
        addr_ok_o = '0;
        if (rd_gnt) addr_ok_o[rd_sel] = 1'b1;
        if (wr_gnt) addr_ok_o[wr_sel] = 1'b1;
    end

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            r_state_q <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            r_dok_q   <= '0;
            r_err_q   <= '0;
            rdata_q   <= '0;
        end else begin
            r_dok_q <= '0;
            r_err_q <= '0;
            case (r_state_q)
                R_IDLE: if (rd_gnt) begin
                    r_addr_q  <= rd_addr;
                    r_size_q  <= rd_size;
                    r_port_q  <= rd_sel;
                    arvalid_q <= 1'b1;
                    r_state_q <= R_AR;
                end
                R_AR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    r_state_q <= R_R;
                end
                R_R: if (rvalid_i && rlast_i) begin
                    rready_q          <= 1'b0;
                    rdata_q           <= rdata_axi_i;
                    r_dok_q[r_port_q] <= 1'b1;
                    r_err_q[r_port_q] <= (rresp_i != 2'b00);
                    r_state_q         <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            w_state_q <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            w_dok_q   <= '0;
            w_err_q   <= '0;
        end else begin
            w_dok_q <= '0;
            w_err_q <= '0;
            case (w_state_q)
                W_IDLE: if (wr_gnt) begin
                    w_addr_q  <= wr_addr;
                    w_size_q  <= wr_size;
                    w_data_q  <= wr_data;
                    w_port_q  <= wr_sel;
                    w_strb_q  <= strb_f(wr_size, wr_addr[1:0]);
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    w_state_q <= W_AW;
                end
                W_AW: begin
                    // A dropped valid marks its channel as done; B waits for both.
                    if (awready_i) awvalid_q <= 1'b0;
                    if (wready_i)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        bready_q  <= 1'b1;
                        w_state_q <= W_B;
                    end
                end
                W_B: if (bvalid_i) begin
                    bready_q          <= 1'b0;
                    w_dok_q[w_port_q] <= 1'b1;
                    w_err_q[w_port_q] <= (bresp_i != 2'b00);
                    w_state_q         <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign data_ok_o   = r_dok_q | w_dok_q;
    assign bus_err_o   = r_err_q | w_err_q;
    assign rdata_o     = rdata_q;

    assign arid_o      = ID_W'(r_port_q);
    assign araddr_o    = r_addr_q;
    assign arlen_o     = 4'd0;
    assign arsize_o    = {1'b0, r_size_q};
    assign arburst_o   = 2'b01;
    assign arlock_o    = 2'b00;
    assign arcache_o   = 4'd0;
    assign arprot_o    = 3'd0;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;

    assign awid_o      = ID_W'(w_port_q);
    assign awaddr_o    = w_addr_q;
    assign awlen_o     = 4'd0;
    assign awsize_o    = {1'b0, w_size_q};
    assign awburst_o   = 2'b01;
    assign awlock_o    = 2'b00;
    assign awcache_o   = 4'd0;
    assign awprot_o    = 3'd0;
    assign awvalid_o   = awvalid_q;
    assign wid_o       = ID_W'(w_port_q);
    assign wdata_axi_o = w_data_q;
    assign wstrb_o     = w_strb_q;
    assign wlast_o     = 1'b1;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Scoreboard bench for axi_sram_bridge_mp: ports request, a delay-configurable AXI slave responds,
// expected transactions are queued on grant and compared at the AXI handshakes and at data_ok.
module tb_axi_sram_bridge_mp;
    localparam int NP = 2;
    localparam int IDW = 4;
    localparam int AW = 32;

    logic aclk_i = 1'b0;
    always #5 aclk_i = ~aclk_i;

    logic              aresetn_i;
    logic [NP-1:0]     req_i, wr_i;
    logic [2*NP-1:0]   size_i;
    logic [AW*NP-1:0]  addr_i;
    logic [32*NP-1:0]  wdata_i;
    logic [NP-1:0]     addr_ok_o, data_ok_o, bus_err_o;
    logic [31:0]       rdata_o;
    logic [IDW-1:0]    arid_o, awid_o, wid_o;
    logic [AW-1:0]     araddr_o, awaddr_o;
    logic [3:0]        arlen_o, arcache_o, awlen_o, awcache_o, wstrb_o;
    logic [2:0]        arsize_o, arprot_o, awsize_o, awprot_o;
    logic [1:0]        arburst_o, arlock_o, awburst_o, awlock_o;
    logic              arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o;
    logic [31:0]       wdata_axi_o;
    logic              arready_i = 0, rvalid_i = 0, rlast_i = 1, awready_i = 0, wready_i = 0, bvalid_i = 0;
    logic [IDW-1:0]    rid_i = '0, bid_i = '0;
    logic [31:0]       rdata_axi_i = '0;
    logic [1:0]        rresp_i = '0, bresp_i = '0;

    axi_sram_bridge_mp #(.N_PORTS(NP), .ID_W(IDW), .ADDR_W(AW)) dut (
        .aclk_i(aclk_i), .aresetn_i(aresetn_i), .req_i(req_i), .wr_i(wr_i), .size_i(size_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .addr_ok_o(addr_ok_o), .data_ok_o(data_ok_o),
        .rdata_o(rdata_o), .bus_err_o(bus_err_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o), .arprot_o(arprot_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .rid_i(rid_i), .rdata_axi_i(rdata_axi_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awlock_o(awlock_o), .awcache_o(awcache_o), .awprot_o(awprot_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .wid_o(wid_o), .wdata_axi_o(wdata_axi_o),
        .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [3:0] strb_model(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) begin
            case (a)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // slave configuration
    int       ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic     r_hold = 0, b_hold = 0;
    logic [1:0] cfg_rresp = 0, cfg_bresp = 0;

    // monitor state (sampled 2 time units after each falling edge)
    int   cyc = 0;
    logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, pend_rd = 0, pend_wr = 0;
    logic [31:0] ar_addr_s = '0;
    int   n_ar = 0, n_aw = 0, n_w = 0, n_rd_done = 0, n_dok = 0;
    int   dok_cyc[NP];
    int   gnt_cyc[NP];
    exp_t m_it;
    logic [NP-1:0] e_dok, e_err;

    always @(negedge aclk_i) begin
        cyc++;
        #2;
        if (!aresetn_i) begin
            {ar_hs, r_hs, aw_hs, w_hs, b_hs, pend_rd, pend_wr} = '0;
        end else begin
            e_dok = '0;
            e_err = '0;
            if (pend_rd) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    m_it = rd_q.pop_front();
                    e_dok[m_it.port] = 1'b1;
                    e_err[m_it.port] = m_it.err;
                    chk("rdata", rdata_o, m_it.data);
                    n_rd_done++;
                end
            end
            if (pend_wr) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    m_it = wr_q.pop_front();
                    e_dok[m_it.port] = 1'b1;
                    e_err[m_it.port] = m_it.err;
                end
            end
            if (pend_rd || pend_wr || data_ok_o != '0) begin
                chk("data_ok", data_ok_o, e_dok);
                chk("bus_err", bus_err_o, e_err);
            end
            for (int p = 0; p < NP; p++)
                if (data_ok_o[p]) begin dok_cyc[p] = cyc; n_dok++; end

            ar_hs = arvalid_o && arready_i;
            if (ar_hs) begin
                n_ar++;
                ar_addr_s = araddr_o;
                if (rd_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    chk("arid", arid_o, rd_q[0].port);
                    chk("araddr", araddr_o, rd_q[0].addr);
                    chk("arsize", arsize_o, {1'b0, rd_q[0].size});
                    chk("ar_const", {arlen_o, arburst_o, arlock_o, arcache_o, arprot_o},
                        {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
                end
            end
            r_hs    = rvalid_i && rready_o;
            pend_rd = r_hs && rlast_i;

            aw_hs = awvalid_o && awready_i;
            w_hs  = wvalid_o && wready_i;
            if ((aw_hs || w_hs) && wr_q.size() == 0) chk("aw_w_unexpected", 1, 0);
            else begin
                if (aw_hs) begin
                    n_aw++;
                    chk("awid", awid_o, wr_q[0].port);
                    chk("awaddr", awaddr_o, wr_q[0].addr);
                    chk("awsize", awsize_o, {1'b0, wr_q[0].size});
                    chk("aw_const", {awlen_o, awburst_o, awlock_o, awcache_o, awprot_o},
                        {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
                end
                if (w_hs) begin
                    n_w++;
                    chk("wdata", wdata_axi_o, wr_q[0].data);
                    chk("wstrb", wstrb_o, strb_model(wr_q[0].size, wr_q[0].addr[1:0]));
                    chk("wlast_wid", {wlast_o, wid_o}, {1'b1, 4'(wr_q[0].port)});
                end
            end
            b_hs    = bvalid_i && bready_o;
            pend_wr = b_hs;
        end
    end

    // AXI slave: reacts on the falling edge to handshakes the monitor saw before the last rising edge.
    int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic r_pend = 0, aw_seen = 0, w_seen = 0;
    always @(negedge aclk_i) begin
        if (!aresetn_i) begin
            {arready_i, rvalid_i, awready_i, wready_i, bvalid_i} = '0;
            {r_pend, aw_seen, w_seen} = '0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (r_hs) rvalid_i = 1'b0;
            if (ar_hs) begin
                arready_i = 1'b0; ar_cnt = 0; r_pend = 1'b1;
                rdata_axi_i = rd_model(ar_addr_s);
                rresp_i = cfg_rresp;
            end else if (arvalid_o && !arready_i) begin
                ar_cnt++;
                if (ar_cnt > ar_delay) arready_i = 1'b1;
            end
            if (r_pend && !r_hold && !rvalid_i) begin rvalid_i = 1'b1; r_pend = 1'b0; end

            if (aw_hs) begin awready_i = 1'b0; aw_cnt = 0; aw_seen = 1'b1; end
            else if (awvalid_o && !awready_i) begin
                aw_cnt++;
                if (aw_cnt > aw_delay) awready_i = 1'b1;
            end
            if (w_hs) begin wready_i = 1'b0; w_cnt = 0; w_seen = 1'b1; end
            else if (wvalid_o && !wready_i) begin
                w_cnt++;
                if (w_cnt > w_delay) wready_i = 1'b1;
            end
            if (b_hs) bvalid_i = 1'b0;
            if (aw_seen && w_seen && !b_hold && !bvalid_i) begin
                bvalid_i = 1'b1; bresp_i = cfg_bresp; aw_seen = 1'b0; w_seen = 1'b0;
            end
        end
    end

    task automatic issue(input int p, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t it;
        bit   got;
        @(negedge aclk_i);
        req_i[p] = 1'b1; wr_i[p] = w; size_i[2*p +: 2] = sz;
        addr_i[32*p +: 32] = a; wdata_i[32*p +: 32] = d;
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            #2;
            if (addr_ok_o[p]) begin
                got = 1;
                gnt_cyc[p] = cyc;
                it.port = p; it.addr = a; it.size = sz;
                it.data = w ? d : rd_model(a);
                it.err  = w ? (cfg_bresp != 0) : (cfg_rresp != 0);
                if (w) wr_q.push_back(it); else rd_q.push_back(it);
            end
            @(negedge aclk_i);
        end
        req_i[p] = 1'b0;
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && k < 500) begin
            @(negedge aclk_i);
            k++;
        end
        if (rd_q.size() != 0 || wr_q.size() != 0) chk({tag, "_idle_timeout"}, 0, 1);
        repeat (2) @(negedge aclk_i);
    endtask

    int  base_a, base_b;
    bit  seen;
    logic [1:0]  st_sz[4]  = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic [31:0] st_adr[4] = '{32'h10, 32'h12, 32'h10, 32'h14};

    initial begin
        for (int p = 0; p < NP; p++) begin dok_cyc[p] = -1; gnt_cyc[p] = -1; end
        aresetn_i = 1'b0; req_i = '0; wr_i = '0; size_i = '0; addr_i = '0; wdata_i = '0;
        req_i[0] = 1'b1;
        repeat (3) @(negedge aclk_i);
        #2;
        chk("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 5'd0);
        chk("rst_pulses", {addr_ok_o, data_ok_o, bus_err_o}, '0);
        chk("rst_rdata", rdata_o, 32'd0);
        @(negedge aclk_i);
        req_i = '0;
        aresetn_i = 1'b1;

        // single read with late arready
        ar_delay = 2;
        issue(0, 0, 2'd2, 32'hBFC0_0000, 32'd0);
        wait_idle("single_read");
        chk("single_rdata_hold", rdata_o, 32'h3C1D_BFC0);
        chk("single_ar_count", n_ar, 1);

        // priority: both ports read in the same cycle
        ar_delay = 0;
        fork
            issue(0, 0, 2'd2, 32'h0000_0100, 32'd0);
            issue(1, 0, 2'd2, 32'h0000_0200, 32'd0);
        join
        wait_idle("prio");
        chk("prio_p1_first", gnt_cyc[1] < gnt_cyc[0], 1);
        chk("prio_p0_after_dok", gnt_cyc[0] >= dok_cyc[1], 1);

        // byte store with awready trailing wready
        w_delay = 0; aw_delay = 3;
        base_a = n_aw; base_b = n_w;
        issue(1, 1, 2'd0, 32'h8000_0003, 32'hAAAA_AAAA);
        wait_idle("byte_store");
        chk("byte_aw_count", n_aw - base_a, 1);
        chk("byte_w_count", n_w - base_b, 1);

        // store sizes and offsets
        aw_delay = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 1, st_sz[i], st_adr[i], 32'h1111_0000 + i);
            wait_idle("store_tbl");
        end

        // read-after-write hazard while the write response is withheld
        b_hold = 1'b1;
        issue(0, 1, 2'd2, 32'h0000_1000, 32'h1234_5678);
        gnt_cyc[1] = -1;
        base_a = n_rd_done;
        fork
            issue(1, 0, 2'd2, 32'h0000_1002, 32'd0);
            begin
                issue(0, 0, 2'd2, 32'h0000_2000, 32'd0);
                repeat (15) @(negedge aclk_i);
                chk("raw_other_read_done", n_rd_done - base_a, 1);
                chk("raw_blocked", gnt_cyc[1] == -1, 1);
                b_hold = 1'b0;
            end
        join
        wait_idle("raw");
        chk("raw_after_wdok", gnt_cyc[1] >= dok_cyc[0], 1);

        // concurrent read and write
        fork
            issue(0, 0, 2'd2, 32'h0000_3000, 32'd0);
            issue(1, 1, 2'd2, 32'h0000_4000, 32'hCAFE_F00D);
        join
        #2;
        chk("conc_same_cycle", gnt_cyc[0] == gnt_cyc[1], 1);
        chk("conc_valids", {arvalid_o, awvalid_o}, 2'b11);
        wait_idle("conc");

        // error responses
        cfg_rresp = 2'b10;
        issue(0, 0, 2'd2, 32'h0000_5000, 32'd0);
        wait_idle("rd_err");
        cfg_rresp = 2'b00;
        cfg_bresp = 2'b10;
        issue(1, 1, 2'd2, 32'h0000_5100, 32'h5555_0000);
        wait_idle("wr_err");
        cfg_bresp = 2'b00;

        // reset while waiting for read data
        r_hold = 1'b1;
        issue(0, 0, 2'd2, 32'h0000_6000, 32'd0);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            #2;
            if (rready_o) seen = 1;
            @(negedge aclk_i);
        end
        chk("rst_reached_rr", seen, 1);
        aresetn_i = 1'b0;
        @(negedge aclk_i);
        #2;
        chk("midrst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 5'd0);
        chk("midrst_pulses", {data_ok_o, bus_err_o}, '0);
        chk("midrst_rdata", rdata_o, 32'd0);
        rd_q.delete();
        r_hold = 1'b0;
        base_a = n_dok;
        @(negedge aclk_i);
        aresetn_i = 1'b1;
        repeat (8) @(negedge aclk_i);
        chk("midrst_no_dok", n_dok - base_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
